// File: rtl/tile_buffer_scroll.sv
// Dual-port tile screen buffer with ready/valid writes, hardware vertical scroll and clear sweeps.
// Defining TILE_ATTR_EN adds a per-tile attribute plane (attr_i / attr_o).
module tile_buffer_scroll #(
  parameter int H_TILES        = 160,
  parameter int V_TILES        = 60,
  parameter int ADDR_COL_WIDTH = 8,
  parameter int ADDR_ROW_WIDTH = 6,
  parameter int DATA_WIDTH     = 7,
  parameter int ATTR_WIDTH     = 8,
  parameter int FILL_CHAR      = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [ADDR_COL_WIDTH-1:0] col_w_i,
  input  logic [ADDR_ROW_WIDTH-1:0] row_w_i,
  input  logic [DATA_WIDTH-1:0]     din_i,
  input  logic [ADDR_COL_WIDTH-1:0] col_r_i,
  input  logic [ADDR_ROW_WIDTH-1:0] row_r_i,
  output logic [DATA_WIDTH-1:0]     dout_o,
  input  logic                      clear_i,
  input  logic                      scroll_i,
  output logic [ADDR_ROW_WIDTH-1:0] scroll_o,
  output logic                      busy_o
`ifdef TILE_ATTR_EN
  ,
  input  logic [ATTR_WIDTH-1:0]     attr_i,
  output logic [ATTR_WIDTH-1:0]     attr_o
`endif
);

  localparam int NUM_TILES = H_TILES * V_TILES;
`ifdef TILE_ATTR_EN
  localparam bit ATTR_ON = 1'b1;
`else
  localparam bit ATTR_ON = 1'b0;
`endif
  localparam int WORD_W = DATA_WIDTH + (ATTR_ON ? ATTR_WIDTH : 0);
  localparam int ADDR_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  localparam logic [ADDR_COL_WIDTH:0] H_LIM     = (ADDR_COL_WIDTH + 1)'(H_TILES);
  localparam logic [ADDR_ROW_WIDTH:0] V_LIM     = (ADDR_ROW_WIDTH + 1)'(V_TILES);
  localparam logic [ADDR_W-1:0]       LAST_TILE = ADDR_W'(NUM_TILES - 1);
  localparam logic [ADDR_W-1:0]       LAST_COL  = ADDR_W'(H_TILES - 1);
  localparam logic [WORD_W-1:0]       FILL_WORD = WORD_W'(DATA_WIDTH'(FILL_CHAR));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2
  } state_t;

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [ADDR_W-1:0]           ptr_r;
  logic [ADDR_W-1:0]           base_r;
  logic [ADDR_ROW_WIDTH-1:0]   offset_r;
  logic [ADDR_ROW_WIDTH:0]     offset_sum_s;
  logic [ADDR_ROW_WIDTH-1:0]   offset_inc_s;

  logic [WORD_W-1:0]           mem_r [NUM_TILES];
  logic                        mem_we_s;
  logic [ADDR_W-1:0]           mem_waddr_s;
  logic [WORD_W-1:0]           mem_wdata_s;
  logic [WORD_W-1:0]           wr_word_s;
  logic                        wr_ok_s;
  logic [ADDR_W-1:0]           wr_addr_s;
  logic                        rd_ok_s;
  logic [ADDR_W-1:0]           rd_addr_s;
  logic [WORD_W-1:0]           rd_word_r;

  // Logical row to physical row; row + offset can exceed V_TILES only once for in-range rows.
  function automatic logic [ADDR_ROW_WIDTH:0] remap_row(
    input logic [ADDR_ROW_WIDTH-1:0] row,
    input logic [ADDR_ROW_WIDTH-1:0] off
  );
    logic [ADDR_ROW_WIDTH:0] sum;
    sum = {1'b0, row} + {1'b0, off};
    if (sum >= V_LIM) begin
      remap_row = sum - V_LIM;
    end else begin
      remap_row = sum;
    end
  endfunction

  function automatic logic [ADDR_W-1:0] tile_addr(
    input logic [ADDR_ROW_WIDTH:0]   prow,
    input logic [ADDR_COL_WIDTH-1:0] col
  );
    tile_addr = ADDR_W'(int'(prow) * H_TILES + int'(col));
  endfunction

  function automatic logic coord_ok(
    input logic [ADDR_COL_WIDTH-1:0] col,
    input logic [ADDR_ROW_WIDTH-1:0] row
  );
    coord_ok = ({1'b0, col} < H_LIM) && ({1'b0, row} < V_LIM);
  endfunction

`ifdef TILE_ATTR_EN
  assign wr_word_s = {attr_i, din_i};
  assign attr_o    = rd_word_r[WORD_W-1:DATA_WIDTH];
`else
  assign wr_word_s = din_i;
`endif

  assign dout_o       = rd_word_r[DATA_WIDTH-1:0];
  assign wr_ready_o   = (state_r == IDLE);
  assign busy_o       = (state_r != IDLE);
  assign scroll_o     = offset_r;
  assign offset_sum_s = {1'b0, offset_r} + {{ADDR_ROW_WIDTH{1'b0}}, 1'b1};
  assign offset_inc_s = (offset_sum_s == V_LIM) ? {ADDR_ROW_WIDTH{1'b0}}
                                                : offset_sum_s[ADDR_ROW_WIDTH-1:0];
  assign wr_ok_s      = coord_ok(col_w_i, row_w_i);
  assign wr_addr_s    = tile_addr(remap_row(row_w_i, offset_r), col_w_i);
  assign rd_ok_s      = coord_ok(col_r_i, row_r_i);
  assign rd_addr_s    = tile_addr(remap_row(row_r_i, offset_r), col_r_i);

  // Sequencer next state: clear has priority over scroll, pulses while busy are dropped.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (clear_i) begin
          state_nxt_s = CLEAR;
        end else if (scroll_i) begin
          state_nxt_s = SCROLL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        if (ptr_r == LAST_TILE) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      SCROLL: begin
        if (ptr_r == LAST_COL) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SCROLL;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, sweep pointer/base and scroll offset registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= CLEAR;
      ptr_r    <= {ADDR_W{1'b0}};
      base_r   <= {ADDR_W{1'b0}};
      offset_r <= {ADDR_ROW_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          ptr_r <= {ADDR_W{1'b0}};
          if (clear_i) begin
            base_r <= {ADDR_W{1'b0}};
          end else if (scroll_i) begin
            // The old top physical row becomes the new logical bottom row.
            base_r   <= tile_addr({1'b0, offset_r}, {ADDR_COL_WIDTH{1'b0}});
            offset_r <= offset_inc_s;
          end
        end
        CLEAR, SCROLL: ptr_r <= ptr_r + ADDR_W'(1'b1);
        default:       ptr_r <= {ADDR_W{1'b0}};
      endcase
    end
  end

  // Single memory write port shared by sweeps and the user write channel.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = {ADDR_W{1'b0}};
    mem_wdata_s = FILL_WORD;
    case (state_r)
      CLEAR, SCROLL: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = base_r + ptr_r;
        mem_wdata_s = FILL_WORD;
      end
      IDLE: begin
        if (wr_valid_i && wr_ok_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = wr_addr_s;
          mem_wdata_s = wr_word_s;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: mem_we_s = 1'b0;
    endcase
  end

  // Tile memory write.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Registered read port; a same-cycle write to the same tile returns the old word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_word_r <= {WORD_W{1'b0}};
    end else if (rd_ok_s) begin
      rd_word_r <= mem_r[rd_addr_s];
    end else begin
      rd_word_r <= {WORD_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_tile_buffer_scroll.sv
// Self-checking bench for tile_buffer_scroll (4x3 screen) against a logical-screen reference model.
module tb_tile_buffer_scroll;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int CW = 8;
  localparam int RW = 6;
  localparam int DW = 7;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [CW-1:0] col_w = '0;
  logic [RW-1:0] row_w = '0;
  logic [DW-1:0] din = '0;
  logic [CW-1:0] col_r = '0;
  logic [RW-1:0] row_r = '0;
  logic [DW-1:0] dout;
  logic          clear = 1'b0;
  logic          scroll = 1'b0;
  logic [RW-1:0] scroll_off;
  logic          busy;
`ifdef TILE_ATTR_EN
  logic [AW-1:0] attr_in = '0;
  logic [AW-1:0] attr_out;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: the screen as the user sees it, in logical rows.
  logic [DW-1:0] scr [V][H];
  int            off_m = 0;

  tile_buffer_scroll #(.H_TILES(H), .V_TILES(V)) dut (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .col_w_i(col_w), .row_w_i(row_w), .din_i(din),
    .col_r_i(col_r), .row_r_i(row_r), .dout_o(dout),
    .clear_i(clear), .scroll_i(scroll), .scroll_o(scroll_off), .busy_o(busy)
`ifdef TILE_ATTR_EN
    , .attr_i(attr_in), .attr_o(attr_out)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_read(input int c, input int r);
    if (c < H && r < V) return scr[r][c];
    return '0;
  endfunction

  task automatic model_scroll;
    for (int r = 0; r < V - 1; r++)
      for (int c = 0; c < H; c++) scr[r][c] = scr[r+1][c];
    for (int c = 0; c < H; c++) scr[V-1][c] = '0;
    off_m = (off_m + 1) % V;
  endtask

  task automatic model_clear;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) scr[r][c] = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick;
      n++;
    end
  endtask

  task automatic write_tile(input int c, input int r, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (wr_ready !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL write_ready_timeout got=%b want=1", wr_ready);
    end
    wr_valid = 1'b1;
    col_w = CW'(c);
    row_w = RW'(r);
    din = d;
    tick;
    wr_valid = 1'b0;
    if (c < H && r < V) scr[r][c] = d;
  endtask

  task automatic read_check(input int c, input int r);
    logic [DW-1:0] want;
    want = exp_read(c, r);
    col_r = CW'(c);
    row_r = RW'(r);
    tick;
    checks++;
    if (dout !== want) begin
      failures++;
      $display("FAIL read(%0d,%0d) got=%h want=%h", c, r, dout, want);
    end
  endtask

  task automatic check_all;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) read_check(c, r);
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (3) tick;
    checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0 || dout !== '0 || scroll_off !== '0) begin
      failures++;
      $display("FAIL reset_state got busy=%b ready=%b dout=%h off=%0d want 1 0 00 0",
               busy, wr_ready, dout, scroll_off);
    end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      checks++;
      if (wr_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_sweep_ready cycle=%0d got=%b want=0", n, wr_ready);
      end
      tick;
      n++;
    end
    checks++;
    if (n != H * V || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_sweep_len got=%0d ready=%b want=%0d ready=1", n, wr_ready, H * V);
    end
    model_clear();
    off_m = 0;
    check_all();
  endtask

  task automatic test_write_read;
    write_tile(1, 2, 7'h41);
    read_check(1, 2);
    write_tile(4, 0, 7'h7f);
    write_tile(0, 3, 7'h7f);
    check_all();
    read_check(5, 1);
    read_check(2, 7);
    // same tile read and written in one cycle returns the previous contents
    write_tile(2, 1, 7'h11);
    wr_valid = 1'b1;
    col_w = CW'(2);
    row_w = RW'(1);
    din = 7'h22;
    col_r = CW'(2);
    row_r = RW'(1);
    tick;
    wr_valid = 1'b0;
    checks++;
    if (dout !== 7'h11) begin
      failures++;
      $display("FAIL same_addr_old_data got=%h want=11", dout);
    end
    scr[1][2] = 7'h22;
    read_check(2, 1);
  endtask

  task automatic test_scroll;
    int n;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) write_tile(c, r, DW'(8'h41 + r));
    scroll = 1'b1;
    tick;
    scroll = 1'b0;
    model_scroll();
    wait_idle(n);
    checks++;
    if (n != H || scroll_off !== RW'(off_m)) begin
      failures++;
      $display("FAIL scroll_busy got=%0d off=%0d want=%0d off=%0d", n, scroll_off, H, off_m);
    end
    check_all();
  endtask

  task automatic test_wrap;
    int n;
    logic [DW-1:0] d;
    for (int k = 0; k < 3; k++) begin
      d = DW'($urandom);
      write_tile(0, 2, d);
      read_check(0, 2);
      scroll = 1'b1;
      tick;
      scroll = 1'b0;
      model_scroll();
      read_check(0, 1);   // issued while the sweep runs, already uses the new offset
      wait_idle(n);
      checks++;
      if (n != H - 1 || scroll_off !== RW'(off_m)) begin
        failures++;
        $display("FAIL wrap_step%0d got busy=%0d off=%0d want busy=%0d off=%0d",
                 k, n, scroll_off, H - 1, off_m);
      end
      check_all();
    end
  endtask

  task automatic test_clear_scroll;
    int n;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) write_tile(c, r, DW'($urandom));
    clear = 1'b1;
    scroll = 1'b1;
    tick;
    clear = 1'b0;
    scroll = 1'b0;
    model_clear();
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      clear = (n == 3);
      scroll = (n == 3);
      wr_valid = (n == H * V - 1);
      col_w = '0;
      row_w = '0;
      din = 7'h7f;
      tick;
      n++;
    end
    clear = 1'b0;
    scroll = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (n != H * V || scroll_off !== RW'(off_m)) begin
      failures++;
      $display("FAIL clear_priority got busy=%0d off=%0d want busy=%0d off=%0d",
               n, scroll_off, H * V, off_m);
    end
    check_all();
  endtask

  task automatic test_back_to_back;
    int op;
    int n;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 19);
      if (op == 0) begin
        scroll = 1'b1;
        tick;
        scroll = 1'b0;
        model_scroll();
        wait_idle(n);
        checks++;
        if (n != H || scroll_off !== RW'(off_m)) begin
          failures++;
          $display("FAIL b2b_scroll got busy=%0d off=%0d want busy=%0d off=%0d",
                   n, scroll_off, H, off_m);
        end
      end else if (op < 9) begin
        write_tile($urandom_range(0, H + 1), $urandom_range(0, V + 1), DW'($urandom));
      end else begin
        read_check($urandom_range(0, H + 1), $urandom_range(0, V + 1));
      end
    end
    check_all();
  endtask

`ifdef TILE_ATTR_EN
  task automatic test_attr;
    int n;
    attr_in = 8'hA5;
    write_tile(3, 1, 7'h5a);
    attr_in = '0;
    col_r = CW'(3);
    row_r = RW'(1);
    tick;
    checks++;
    if (attr_out !== 8'hA5 || dout !== 7'h5a) begin
      failures++;
      $display("FAIL attr_read got=%h/%h want=a5/5a", attr_out, dout);
    end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    model_clear();
    wait_idle(n);
    tick;
    checks++;
    if (attr_out !== '0 || dout !== '0) begin
      failures++;
      $display("FAIL attr_clear got=%h/%h want=00/00", attr_out, dout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_scroll();
    test_wrap();
    test_clear_scroll();
    test_back_to_back();
`ifdef TILE_ATTR_EN
    test_attr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
